// File: rtl/store_merge.sv
// store_merge: narrows 32-bit stores into a word-only memory (RMW for byte/half).
// Optional trap on misaligned half/word stores: define STORE_MISALIGN_TRAP_EN.
module store_merge (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE
`ifdef STORE_MISALIGN_TRAP_EN
    , ERR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] buf_q, buf_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        done_q, done_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        accept;
  logic        is_word;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic        bad;
`endif

  // Replace the addressed lane(s) of w with the low bits of d.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign is_word   = req_size[1];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
  assign bad = is_word ? (req_addr[1:0] != 2'b00)
                       : (req_size[0] && req_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Next state, latched request fields and registered output values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          data_d = req_data;
          size_d = req_size;
`ifdef STORE_MISALIGN_TRAP_EN
          if (bad) begin
            state_d = ERR;
          end else
`endif
          if (is_word) begin
            buf_d   = req_data;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = MERGE;
      MERGE: begin
        buf_d   = merge_lanes(mem_rdata, data_q,
                              size_q, addr_q[1:0]);
        state_d = WRITE;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      addr_d  = '0;
      data_d  = '0;
      size_d  = '0;
      buf_d   = '0;
    end
    mem_rd_d    = (state_d == READ);
    mem_wr_d    = (state_d == WRITE);
    done_d      = (state_d == WRITE);
    mem_addr_d  = (mem_rd_d || mem_wr_d)
                ? {addr_d[31:2], 2'b00} : '0;
    mem_wdata_d = mem_wr_d ? buf_d : '0;
`ifdef STORE_MISALIGN_TRAP_EN
    misalign_d  = (state_d == ERR);
`endif
  end

  // State, request fields and output registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    addr_q      <= addr_d;
    data_q      <= data_d;
    size_q      <= size_d;
    buf_q       <= buf_d;
    mem_rd_q    <= mem_rd_d;
    mem_wr_q    <= mem_wr_d;
    done_q      <= done_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
`ifdef STORE_MISALIGN_TRAP_EN
    misalign_q  <= misalign_d;
`endif
  end

endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge: scoreboard bench for store_merge with a word memory model.
// Follows STORE_MISALIGN_TRAP_EN to pick misaligned-store expectations.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int fails  = 0;

  logic [63:0] sbq[$];
  logic [31:0] mem[0:63];
  logic [31:0] ref_mem[0:63];

  store_merge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .req_size(req_size), .busy(busy), .done(done),
    .misalign(misalign), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_wr === 1'b1) mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    logic [63:0] e;
    checks++;
    if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
      fails++;
      $display("FAIL strobe_overlap rd=%0b wr=%0b, required not both", mem_rd, mem_wr);
    end
    if (mem_wr === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = sbq.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          fails++;
          $display("FAIL sb_write got %h/%h, required %h/%h", mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] s);
    logic [31:0] mask;
    logic [31:0] val;
    int sh;
    if (s == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
      val = (d & 32'h0000_00FF) << sh;
      return (old & ~mask) | val;
    end else if (s == 2'b01) begin
      sh = a[1] ? 16 : 0;
      mask = 32'h0000_FFFF << sh;
      val = (d & 32'h0000_FFFF) << sh;
      return (old & ~mask) | val;
    end
    return d;
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit wr);
    int n = 0;
    logic [31:0] e;
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_size = s;
    while (!req_ready && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (!req_ready) begin
      fails++;
      $display("FAIL accept_timeout ready=%0b, required 1", req_ready);
    end
    cyc();
    req_valid = 1'b0;
    req_addr = $urandom;
    req_data = $urandom;
    req_size = 2'($urandom);
    if (wr) begin
      e = model(ref_mem[a[7:2]], a, d, s);
      sbq.push_back({a & 32'hFFFF_FFFC, e});
      ref_mem[a[7:2]] = e;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    cyc();
    cyc();
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b, required 0", req_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b, required 0", done); end
    checks++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign got %b, required 0", misalign); end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin fails++; $display("FAIL rst_strobes got %b%b, required 00", mem_rd, mem_wr); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h, required 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata got %h, required 0", mem_wdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b, required 1", req_ready); end
  endtask

  task automatic test_word();
    issue(32'h10, 32'hDEAD_BEEF, 2'b10, 1'b1);
    checks++; if (mem_wr !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL word_wr wr=%b done=%b, required 1 1", mem_wr, done); end
    checks++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL word_addr got %h, required 10", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL word_wdata got %h, required deadbeef", mem_wdata); end
    checks++; if (mem_rd !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL word_rd rd=%b ready=%b, required 0 0", mem_rd, req_ready); end
    cyc();
    checks++; if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL word_end ready=%b done=%b busy=%b, required 1 0 0", req_ready, done, busy); end
  endtask

  task automatic test_byte();
    set_word(4, 32'h1122_3344);
    issue(32'h13, 32'h0000_00AB, 2'b00, 1'b1);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h10 || mem_wr !== 1'b0) begin fails++; $display("FAIL byte_read rd=%b addr=%h wr=%b, required 1 10 0", mem_rd, mem_addr, mem_wr); end
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL byte_busy busy=%b ready=%b, required 1 0", busy, req_ready); end
    cyc();
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL byte_merge rd=%b wr=%b done=%b, required 0 0 0", mem_rd, mem_wr, done); end
    cyc();
    checks++; if (mem_wr !== 1'b1 || done !== 1'b1 || mem_wdata !== 32'hAB22_3344) begin fails++; $display("FAIL byte_write wr=%b done=%b data=%h, required 1 1 ab223344", mem_wr, done, mem_wdata); end
    cyc();
    checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL byte_end ready=%b done=%b, required 1 0", req_ready, done); end
  endtask

  task automatic test_half();
    set_word(8, 32'hA0B0_C0D0);
    issue(32'h22, 32'hFFFF_5566, 2'b01, 1'b1);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h20) begin fails++; $display("FAIL half_read rd=%b addr=%h, required 1 20", mem_rd, mem_addr); end
    cyc();
    cyc();
    checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h5566_C0D0) begin fails++; $display("FAIL half_write wr=%b data=%h, required 1 5566c0d0", mem_wr, mem_wdata); end
    cyc();
    set_word(9, 32'h0BAD_F00D);
    issue(32'h24, 32'h0000_1234, 2'b01, 1'b1);
    cyc();
    cyc();
    checks++; if (mem_wdata !== 32'h0BAD_1234) begin fails++; $display("FAIL half_low got %h, required 0bad1234", mem_wdata); end
    cyc();
  endtask

  task automatic test_misalign();
    set_word(8, 32'h0102_0304);
    set_word(5, 32'h5555_5555);
`ifdef STORE_MISALIGN_TRAP_EN
    issue(32'h21, 32'h0000_BEEF, 2'b01, 1'b0);
    checks++; if (misalign !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin fails++; $display("FAIL mis_half m=%b rd=%b wr=%b, required 1 0 0", misalign, mem_rd, mem_wr); end
    cyc();
    checks++; if (req_ready !== 1'b1 || misalign !== 1'b0) begin fails++; $display("FAIL mis_half_end ready=%b m=%b, required 1 0", req_ready, misalign); end
    issue(32'h16, 32'h7777_7777, 2'b10, 1'b0);
    checks++; if (misalign !== 1'b1 || mem_wr !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mis_word m=%b wr=%b done=%b, required 1 0 0", misalign, mem_wr, done); end
    cyc();
`else
    issue(32'h21, 32'h0000_BEEF, 2'b01, 1'b1);
    checks++; if (misalign !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 32'h20) begin fails++; $display("FAIL mis_half m=%b rd=%b addr=%h, required 0 1 20", misalign, mem_rd, mem_addr); end
    cyc();
    cyc();
    checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h0102_BEEF) begin fails++; $display("FAIL mis_half_wr wr=%b data=%h, required 1 0102beef", mem_wr, mem_wdata); end
    cyc();
    issue(32'h16, 32'h7777_7777, 2'b10, 1'b1);
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h14 || mem_wdata !== 32'h7777_7777) begin fails++; $display("FAIL mis_word wr=%b addr=%h data=%h, required 1 14 77777777", mem_wr, mem_addr, mem_wdata); end
    cyc();
`endif
  endtask

  task automatic test_reserved();
    issue(32'h40, 32'h1234_5678, 2'b11, 1'b1);
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 32'h1234_5678) begin fails++; $display("FAIL rsv_size wr=%b rd=%b data=%h, required 1 0 12345678", mem_wr, mem_rd, mem_wdata); end
    cyc();
  endtask

  task automatic test_reset_merge();
    issue(32'h13, 32'h0000_00CD, 2'b00, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rm_outs wr=%b rd=%b done=%b busy=%b, required 0 0 0 0", mem_wr, mem_rd, done, busy); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b0) begin fails++; $display("FAIL rm_bus addr=%h data=%h ready=%b, required 0 0 0", mem_addr, mem_wdata, req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got %b, required 1", req_ready); end
    cyc();
    cyc();
    checks++; if (mem[4] !== ref_mem[4]) begin fails++; $display("FAIL rm_mem got %h, required %h", mem[4], ref_mem[4]); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [31:0] e;
    set_word(12, 32'h0);
    req_valid = 1'b1;
    req_addr = 32'h30;
    req_data = 32'hCAFE_F00D;
    req_size = 2'b10;
    cyc();
    e = model(ref_mem[12], 32'h30, 32'hCAFE_F00D, 2'b10);
    sbq.push_back({32'h30, e});
    ref_mem[12] = e;
    req_addr = 32'h31;
    req_data = 32'h0000_0077;
    req_size = 2'b00;
    checks++; if (req_ready !== 1'b0 || mem_wr !== 1'b1) begin fails++; $display("FAIL b2b_hold ready=%b wr=%b, required 0 1", req_ready, mem_wr); end
    while (!req_ready && n < 10) begin
      cyc();
      n++;
    end
    checks++; if (n !== 1) begin fails++; $display("FAIL b2b_gap got %0d cycles, required 1", n); end
    cyc();
    req_valid = 1'b0;
    e = model(ref_mem[12], 32'h31, 32'h0000_0077, 2'b00);
    sbq.push_back({32'h30, e});
    ref_mem[12] = e;
    checks++; if (mem_rd !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL b2b_second rd=%b ready=%b, required 1 0", mem_rd, req_ready); end
    n = 0;
    while (busy && n < 10) begin
      cyc();
      n++;
    end
    checks++; if (busy !== 1'b0 || e !== 32'hCAFE_770D) begin fails++; $display("FAIL b2b_done busy=%b exp=%h, required 0 cafe770d", busy, e); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_word(i, 32'h0);
    mem_rdata = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reserved();
    test_reset_merge();
    test_back_to_back();
    cyc();
    cyc();
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain left %0d, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
